jtdd_mcu_bus: RTL and testbench
===============================

# jtdd_mcu_bus

Parametrised bus and glue block for a 6801-class protection/sound MCU: generates the MCU clock enable with ROM wait states, decodes the MCU address space, and holds the I/O port registers. It also owns the on-chip RAM, the dual-port shared RAM toward the main CPU, the NMI latch and a main-CPU halt handshake. It sits between the MCU core and the game top level, generalising the fixed single-port MCU wrapper to N output ports, a configurable clock divider and an explicit halt/grant protocol.

## Interface
Parameters:
- CEN_DIV, 4: input cen pulses per mcu_cen pulse; legal range 2..16.
- NPORTS, 2: number of exported output port registers.
- PORT0, 5'h17: address of the first exported port; ports occupy PORT0..PORT0+NPORTS-1, all < 0x20.
- SHARED_AW, 9: shared RAM address width.
- ROM_AW, 14: ROM address width.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- cen_in  in  1  base clock enable (6 MHz).
- mcu_cen  out  1  MCU core clock enable, one clk wide.
- mcu_vma / mcu_rnw  in  1 / 1  core bus valid and read-not-write.
- mcu_addr  in  16  core address.
- mcu_dout  in  8  core write data.
- mcu_din  out  8  core read data.
- mcu_halt  out  1  halt request to core.
- mcu_halted  in  1  core halted status.
- mcu_nmi  out  1  NMI to core.
- nmi_set  in  1  NMI source; rising edge sets the latch.
- rom_addr  out  ROM_AW  = mcu_addr[ROM_AW-1:0].
- rom_cs  out  1  ROM select.
- rom_data  in  8  ROM data.
- rom_ok  in  1  ROM data valid.
- port_dout  out  8*NPORTS  exported ports; port k at bits [8k+7:8k].
- irq_main  out  1  = bit 1 of port PORT0.
- halt_req  in  1  main CPU requests shared-RAM ownership.
- halt_ack  out  1  ownership granted.
- cpu_addr  in  SHARED_AW  main CPU shared-RAM address.
- cpu_dout  in  8  main CPU write data.
- cpu_we  in  1  main CPU write strobe; qualified by com_cs.
- com_cs  in  1  main CPU shared-RAM select.
- shared_dout  out  8  shared RAM read data toward the main CPU.

## Operation
- Decode, qualified by mcu_vma:
  - ports: addr < 0x28; registers exist at 0x00–0x1F.
  - internal RAM: 0x0040–0x013F, 256 bytes.
  - shared RAM: addr[15:12]==4'h8, mirrored on SHARED_AW.
  - ROM: addr[15:14]==2'b11.
- Unmapped reads, and port reads at 0x20–0x27, return 8'hFF.
- Writes to ports, internal RAM and shared RAM occur only on the clk where mcu_cen=1 with mcu_vma & ~mcu_rnw.
- Port reads return the last value written.
- NMI latch: set on a registered rising edge of nmi_set. Cleared while port PORT0 bit 0 = 0. Clear dominates a simultaneous set.
- Halt FSM, three states:
  - IDLE: halt_req=1 → REQ.
  - REQ: mcu_halt=1. mcu_halted=1 → GRANT. halt_req=0 → IDLE.
  - GRANT: mcu_halt=1, halt_ack=1. halt_req=0 → IDLE; mcu_halt and halt_ack drop on that same clk edge.
- Main-side shared write requires cpu_we & com_cs & halt_ack; otherwise it is ignored. Main-side reads are always allowed.

## Timing
- Reset values: all ports 0, mcu_nmi 0, irq_main 0, halt FSM IDLE (mcu_halt 0, halt_ack 0), divider 0, wait 0, mcu_cen 0.
- Divider counts cen_in pulses 0..CEN_DIV-1. mcu_cen = cen_in & (count==CEN_DIV-1) & ~wait.
- Wait: set on any clk with rom_cs & ~rom_ok; cleared on any clk with rom_ok.
  - A terminal pulse suppressed by wait stays pending.
  - The pending pulse fires on the first cen_in after wait clears; the divider restarts at 0.
- RAM reads are synchronous, 1 clk latency. mcu_din is stable before the next mcu_cen because CEN_DIV ≥ 2.
- Halt grant latency: 1 clk after mcu_halted is first seen high in REQ.
- rst asserted mid-wait or in GRANT: return to reset values on the next edge. RAM contents are not cleared.

## Configuration
- MCU_ROMWAIT_EN defined: ROM wait logic as above.
- MCU_ROMWAIT_EN undefined: wait is held at 0 and mcu_cen is free-running; rom_ok is ignored; ROM is treated as zero-latency.

## Test plan
- CEN_DIV=4, cen_in every 2 clk, rom_ok=1 → mcu_cen once every 8 clk, first pulse on the 4th cen_in after reset.
- ROM fetch at 0xC000 with rom_ok low for 20 clk → no mcu_cen during the stall; the pending pulse fires on the first cen_in after rom_ok rises; mcu_din = rom_data.
- MCU writes 0x03 to 0x0017 and 0xA5 to 0x0018 (NPORTS=2) → port_dout=16'hA503, irq_main=1, readback of 0x0018 = 0xA5, read of 0x0024 = 0xFF.
- nmi_set pulse with port 0x17 bit0=1 → mcu_nmi=1; MCU writes 0x02 → mcu_nmi=0; nmi_set pulse while bit0=0 → mcu_nmi stays 0.
- halt_req=1, mcu_halted rises 5 clk later → halt_ack one clk later; main writes 0x5A to shared addr 0x010 → MCU reads 0x5A at 0x8010. The same write before halt_ack is ignored.
- rst while in GRANT with a ROM wait pending → halt_ack=0, mcu_halt=0 and mcu_cen resumes normal cadence after reset.

Source files
------------

// File: rtl/jtdd_mcu_bus.sv
// jtdd_mcu_bus
// Bus and glue block for a 6801-class protection/sound MCU.
//   - mcu_cen generation from cen_in (divide by CEN_DIV) with optional ROM wait
//   - address decode: port registers, internal RAM, shared RAM, ROM
//   - 32 port registers (0x00-0x1F); NPORTS of them exported from PORT0 up
//   - 256-byte internal RAM, dual-port shared RAM toward the main CPU
//   - NMI latch and main-CPU halt/grant handshake
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   cen_in / mcu_cen              base enable in, MCU core enable out
//   mcu_vma, mcu_rnw, mcu_addr,
//   mcu_dout / mcu_din            MCU core bus
//   mcu_halt, mcu_halted, mcu_nmi MCU control
//   nmi_set                       NMI source (rising edge sets the latch)
//   rom_addr, rom_cs, rom_data,
//   rom_ok                        ROM interface
//   port_dout, irq_main           exported port registers
//   halt_req, halt_ack            main CPU ownership handshake
//   cpu_addr, cpu_dout, cpu_we,
//   com_cs, shared_dout           main CPU shared RAM port
// Build option: define MCU_ROMWAIT_EN to stall mcu_cen while ROM data is not
// ready (rom_cs & ~rom_ok). Without it mcu_cen free-runs and rom_ok is ignored.
module jtdd_mcu_bus #(
    parameter int         CEN_DIV   = 4,
    parameter int         NPORTS    = 2,
    parameter logic [4:0] PORT0     = 5'h17,
    parameter int         SHARED_AW = 9,
    parameter int         ROM_AW    = 14
)(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cen_in,
    output logic                  mcu_cen,
    input  logic                  mcu_vma,
    input  logic                  mcu_rnw,
    input  logic [15:0]           mcu_addr,
    input  logic [7:0]            mcu_dout,
    output logic [7:0]            mcu_din,
    output logic                  mcu_halt,
    input  logic                  mcu_halted,
    output logic                  mcu_nmi,
    input  logic                  nmi_set,
    output logic [ROM_AW-1:0]     rom_addr,
    output logic                  rom_cs,
    input  logic [7:0]            rom_data,
    input  logic                  rom_ok,
    output logic [8*NPORTS-1:0]   port_dout,
    output logic                  irq_main,
    input  logic                  halt_req,
    output logic                  halt_ack,
    input  logic [SHARED_AW-1:0]  cpu_addr,
    input  logic [7:0]            cpu_dout,
    input  logic                  cpu_we,
    input  logic                  com_cs,
    output logic [7:0]            shared_dout
);
    localparam int CW = $clog2(CEN_DIV);

    typedef enum logic [1:0] {H_IDLE, H_REQ, H_GRANT} halt_t;
    typedef enum logic [2:0] {SRC_NONE, SRC_PORT, SRC_RAM, SRC_SHR, SRC_ROM} src_t;

    // ---------------- clock enable and ROM wait ----------------
    logic [CW-1:0] div_cnt;
    logic          at_term;
    logic          rom_wait;

    assign at_term = (div_cnt == CW'(CEN_DIV - 1));
    assign mcu_cen = cen_in & at_term & ~rom_wait;

    // A suppressed terminal count holds the divider at its last value, so the
    // pulse stays pending until the first cen_in after the wait clears.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt <= '0;
        end else if (cen_in) begin
            if (!at_term)
                div_cnt <= div_cnt + 1'b1;
            else if (!rom_wait)
                div_cnt <= '0;
        end
    end

`ifdef MCU_ROMWAIT_EN
    always_ff @(posedge clk) begin
        if (rst)
            rom_wait <= 1'b0;
        else if (rom_ok)
            rom_wait <= 1'b0;
        else if (rom_cs)
            rom_wait <= 1'b1;
    end
`else
    logic unused_rom_ok;
    assign unused_rom_ok = rom_ok;
    assign rom_wait      = 1'b0;
`endif

    // ---------------- address decode ----------------
    logic       port_hit, ram_hit, shr_hit, mcu_wr;
    logic [7:0] ram_idx;
    src_t       src_d, src_q;

    assign port_hit = mcu_vma && (mcu_addr[15:5] == 11'd0);
    assign ram_hit  = mcu_vma && (mcu_addr >= 16'h0040) && (mcu_addr <= 16'h013F);
    assign shr_hit  = mcu_vma && (mcu_addr[15:12] == 4'h8);
    assign rom_cs   = mcu_vma && (mcu_addr[15:14] == 2'b11);
    assign rom_addr = mcu_addr[ROM_AW-1:0];
    assign mcu_wr   = mcu_cen & mcu_vma & ~mcu_rnw;
    assign ram_idx  = 8'(mcu_addr - 16'h0040);

    always_comb begin
        src_d = SRC_NONE;
        if (port_hit)     src_d = SRC_PORT;
        else if (ram_hit) src_d = SRC_RAM;
        else if (shr_hit) src_d = SRC_SHR;
        else if (rom_cs)  src_d = SRC_ROM;
    end

    always_ff @(posedge clk) begin
        if (rst) src_q <= SRC_NONE;
        else     src_q <= src_d;
    end

    // ---------------- port registers ----------------
    logic [7:0] ports [32];
    logic [7:0] port_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) ports[i] <= 8'h00;
        end else if (mcu_wr && port_hit) begin
            ports[mcu_addr[4:0]] <= mcu_dout;
        end
    end

    always_ff @(posedge clk) port_q <= ports[mcu_addr[4:0]];

    for (genvar k = 0; k < NPORTS; k++) begin : g_port
        assign port_dout[8*k +: 8] = ports[int'(PORT0) + k];
    end
    assign irq_main = ports[PORT0][1];

    // ---------------- RAMs ----------------
    logic [7:0] iram [256];
    logic [7:0] shr  [2**SHARED_AW];
    logic [7:0] iram_q, shr_q;

    always_ff @(posedge clk) begin
        if (mcu_wr && ram_hit) iram[ram_idx] <= mcu_dout;
        iram_q <= iram[ram_idx];
    end

    // Main-side writes land last, but they only happen while the MCU is halted.
    always_ff @(posedge clk) begin
        if (mcu_wr && shr_hit) shr[mcu_addr[SHARED_AW-1:0]] <= mcu_dout;
        if (cpu_we && com_cs && halt_ack) shr[cpu_addr] <= cpu_dout;
        shr_q       <= shr[mcu_addr[SHARED_AW-1:0]];
        shared_dout <= shr[cpu_addr];
    end

    always_comb begin
        mcu_din = 8'hFF;
        case (src_q)
            SRC_PORT: mcu_din = port_q;
            SRC_RAM:  mcu_din = iram_q;
            SRC_SHR:  mcu_din = shr_q;
            SRC_ROM:  mcu_din = rom_data;
            default:  mcu_din = 8'hFF;
        endcase
    end

    // ---------------- NMI latch ----------------
    logic nmi_q, nmi_qq;

    always_ff @(posedge clk) begin
        if (rst) begin
            nmi_q   <= 1'b0;
            nmi_qq  <= 1'b0;
            mcu_nmi <= 1'b0;
        end else begin
            nmi_q  <= nmi_set;
            nmi_qq <= nmi_q;
            if (!ports[PORT0][0])
                mcu_nmi <= 1'b0;
            else if (nmi_q && !nmi_qq)
                mcu_nmi <= 1'b1;
        end
    end

    // ---------------- halt handshake ----------------
    halt_t h_state, h_next;

    always_ff @(posedge clk) begin
        if (rst) h_state <= H_IDLE;
        else     h_state <= h_next;
    end

    always_comb begin
        h_next   = h_state;
        mcu_halt = 1'b0;
        halt_ack = 1'b0;
        case (h_state)
            H_IDLE: begin
                if (halt_req) h_next = H_REQ;
            end
            H_REQ: begin
                mcu_halt = 1'b1;
                if (!halt_req)       h_next = H_IDLE;
                else if (mcu_halted) h_next = H_GRANT;
            end
            H_GRANT: begin
                mcu_halt = 1'b1;
                halt_ack = 1'b1;
                if (!halt_req) h_next = H_IDLE;
            end
            default: h_next = H_IDLE;
        endcase
    end
endmodule

// File: tb/tb_jtdd_mcu_bus.sv
module tb_jtdd_mcu_bus;
    logic        clk, rst, cen_in, mcu_cen;
    logic        mcu_vma, mcu_rnw;
    logic [15:0] mcu_addr;
    logic [7:0]  mcu_dout, mcu_din;
    logic        mcu_halt, mcu_halted, mcu_nmi, nmi_set;
    logic [13:0] rom_addr;
    logic        rom_cs, rom_ok;
    logic [7:0]  rom_data;
    logic [15:0] port_dout;
    logic        irq_main, halt_req, halt_ack;
    logic [8:0]  cpu_addr;
    logic [7:0]  cpu_dout, shared_dout;
    logic        cpu_we, com_cs;

    jtdd_mcu_bus dut (
        .clk(clk), .rst(rst), .cen_in(cen_in), .mcu_cen(mcu_cen),
        .mcu_vma(mcu_vma), .mcu_rnw(mcu_rnw), .mcu_addr(mcu_addr),
        .mcu_dout(mcu_dout), .mcu_din(mcu_din), .mcu_halt(mcu_halt),
        .mcu_halted(mcu_halted), .mcu_nmi(mcu_nmi), .nmi_set(nmi_set),
        .rom_addr(rom_addr), .rom_cs(rom_cs), .rom_data(rom_data), .rom_ok(rom_ok),
        .port_dout(port_dout), .irq_main(irq_main), .halt_req(halt_req),
        .halt_ack(halt_ack), .cpu_addr(cpu_addr), .cpu_dout(cpu_dout),
        .cpu_we(cpu_we), .com_cs(com_cs), .shared_dout(shared_dout)
    );

    // Signal ids for the scoreboard
    localparam int ID_CEN = 0, ID_DIN = 1, ID_PORTS = 2, ID_IRQ = 3, ID_NMI = 4,
                   ID_HALT = 5, ID_ACK = 6, ID_SHR = 7, ID_FIRST = 8, ID_GAP = 9,
                   ID_WIN = 10, ID_DLY = 11;

    typedef struct {
        int          due;
        int          id;
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0, checks = 0, errors = 0;
    int   cen_seen = 0, first_num = 0, gap = 0, last_cen_cyc = 0, cen_total = 0;
    int   win_base = 0, ref_cyc = 0;
    bit   have_first = 0;
    bit   cen_on = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        #1;
        cen_in = cen_on ? ~cen_in : 1'b0;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual timeout, required finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [31:0] actual(int id);
        case (id)
            ID_CEN:   return 32'(mcu_cen);
            ID_DIN:   return 32'(mcu_din);
            ID_PORTS: return 32'(port_dout);
            ID_IRQ:   return 32'(irq_main);
            ID_NMI:   return 32'(mcu_nmi);
            ID_HALT:  return 32'(mcu_halt);
            ID_ACK:   return 32'(halt_ack);
            ID_SHR:   return 32'(shared_dout);
            ID_FIRST: return 32'(first_num);
            ID_GAP:   return 32'(gap);
            ID_WIN:   return 32'(cen_total - win_base);
            ID_DLY:   return 32'(last_cen_cyc - ref_cyc);
            default:  return 32'hDEAD_BEEF;
        endcase
    endfunction

    // Monitor: tracks mcu_cen cadence and retires due expectations.
    always @(negedge clk) begin
        exp_t        e;
        logic [31:0] act;
        if (rst) begin
            cen_seen   = 0;
            first_num  = 0;
            have_first = 0;
        end else begin
            if (cen_in) cen_seen++;
            if (mcu_cen) begin
                cen_total++;
                if (!have_first) begin
                    first_num  = cen_seen;
                    have_first = 1;
                end else begin
                    gap = cyc - last_cen_cyc;
                end
                last_cen_cyc = cyc;
            end
        end
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            e   = sb.pop_front();
            act = actual(e.id);
            checks++;
            if (act !== e.exp) begin
                errors++;
                $display("FAIL %s: actual %0h, required %0h", e.name, act, e.exp);
            end
        end
    end

    task automatic expect_now(int id, logic [31:0] v, string nm);
        sb.push_back('{due: cyc, id: id, exp: v, name: nm});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cen();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!mcu_cen && n < 64);
        if (!mcu_cen) begin
            checks++;
            errors++;
            $display("FAIL wait_cen: actual no mcu_cen in 64 clk, required pulse");
        end
        tick();
    endtask

    task automatic mcu_write(logic [15:0] a, logic [7:0] d);
        mcu_addr = a;
        mcu_dout = d;
        mcu_vma  = 1'b1;
        mcu_rnw  = 1'b0;
        wait_cen();
        mcu_vma  = 1'b0;
        mcu_rnw  = 1'b1;
    endtask

    task automatic mcu_read(logic [15:0] a, logic [7:0] d, string nm);
        mcu_addr = a;
        mcu_vma  = 1'b1;
        mcu_rnw  = 1'b1;
        tick();
        expect_now(ID_DIN, 32'(d), nm);
        tick();
        mcu_vma  = 1'b0;
    endtask

    task automatic nmi_pulse();
        nmi_set = 1'b1;
        tick();
        nmi_set = 1'b0;
        repeat (3) tick();
    endtask

    initial begin
        rst = 1; cen_in = 0; mcu_vma = 0; mcu_rnw = 1; mcu_addr = 16'h0000;
        mcu_dout = 0; mcu_halted = 0; nmi_set = 0; rom_data = 8'h9C; rom_ok = 1;
        halt_req = 0; cpu_addr = 0; cpu_dout = 0; cpu_we = 0; com_cs = 0;

        // Reset state
        repeat (3) tick();
        expect_now(ID_CEN,   0, "reset_mcu_cen");
        expect_now(ID_PORTS, 0, "reset_ports");
        expect_now(ID_IRQ,   0, "reset_irq_main");
        expect_now(ID_NMI,   0, "reset_mcu_nmi");
        expect_now(ID_HALT,  0, "reset_mcu_halt");
        expect_now(ID_ACK,   0, "reset_halt_ack");
        @(negedge clk);
        rst    = 0;
        cen_on = 1;

        // Divider cadence: 4th cen_in, then every 8 clk
        wait_cen();
        expect_now(ID_FIRST, 4, "first_cen_number");
        wait_cen();
        expect_now(ID_GAP, 8, "cen_gap");

        // ROM stall at 0xC000 for 20 clk
        mcu_addr = 16'hC000; mcu_vma = 1; mcu_rnw = 1; rom_ok = 0;
        win_base = cen_total;
        repeat (20) tick();
`ifdef MCU_ROMWAIT_EN
        expect_now(ID_WIN, 0, "cen_during_stall");
`else
        expect_now(ID_WIN, 2, "cen_during_stall");
`endif
        rom_ok  = 1;
        ref_cyc = cyc;
        wait_cen();
`ifdef MCU_ROMWAIT_EN
        expect_now(ID_DLY, 1, "pending_cen_delay");
`else
        expect_now(ID_DLY, 3, "pending_cen_delay");
`endif
        expect_now(ID_DIN, 32'h9C, "rom_read_data");
        wait_cen();
        expect_now(ID_GAP, 8, "cen_gap_after_stall");
        mcu_vma = 0;

        // Port registers
        mcu_write(16'h0017, 8'h03);
        mcu_write(16'h0018, 8'hA5);
        expect_now(ID_PORTS, 32'hA503, "port_dout");
        expect_now(ID_IRQ,   1,        "irq_main_set");
        // write intent away from mcu_cen must be ignored
        mcu_addr = 16'h0018; mcu_dout = 8'h77; mcu_vma = 1; mcu_rnw = 0;
        repeat (2) tick();
        mcu_vma = 0; mcu_rnw = 1;
        mcu_read(16'h0018, 8'hA5, "port18_readback");
        mcu_read(16'h0024, 8'hFF, "port_gap_read");
        mcu_read(16'h0005, 8'h00, "port05_reset_value");

        // NMI latch
        nmi_pulse();
        expect_now(ID_NMI, 1, "nmi_set");
        mcu_write(16'h0017, 8'h02);
        tick();
        expect_now(ID_NMI,   0,        "nmi_cleared");
        expect_now(ID_PORTS, 32'hA502, "port_dout_after_clear");
        nmi_pulse();
        expect_now(ID_NMI, 0, "nmi_masked");

        // Internal RAM and its boundaries
        mcu_write(16'h0040, 8'h11);
        mcu_write(16'h013F, 8'h22);
        mcu_read(16'h0040, 8'h11, "iram_low");
        mcu_read(16'h013F, 8'h22, "iram_high");
        mcu_read(16'h0140, 8'hFF, "unmapped_above_iram");
        mcu_read(16'h003F, 8'hFF, "unmapped_below_iram");

        // Shared RAM and halt handshake
        mcu_write(16'h8010, 8'h33);
        cpu_addr = 9'h010; cpu_dout = 8'h5A; com_cs = 1; cpu_we = 1;
        tick();
        cpu_we = 0;
        tick();
        expect_now(ID_SHR, 32'h33, "shared_write_without_ack");
        mcu_read(16'h8010, 8'h33, "mcu_shared_before_grant");
        halt_req = 1;
        tick();
        expect_now(ID_HALT, 1, "req_mcu_halt");
        expect_now(ID_ACK,  0, "req_no_ack");
        repeat (4) tick();
        mcu_halted = 1;
        expect_now(ID_ACK, 0, "ack_not_early");
        tick();
        expect_now(ID_ACK,  1, "grant_ack");
        expect_now(ID_HALT, 1, "grant_mcu_halt");
        cpu_we = 1;
        tick();
        cpu_we = 0;
        tick();
        expect_now(ID_SHR, 32'h5A, "shared_write_granted");
        com_cs = 0; cpu_dout = 8'h66; cpu_we = 1;
        tick();
        cpu_we = 0;
        tick();
        expect_now(ID_SHR, 32'h5A, "shared_write_no_cs");
        mcu_read(16'h8010, 8'h5A, "mcu_shared_read");
        mcu_read(16'h8210, 8'h5A, "mcu_shared_mirror");
        halt_req = 0;
        tick();
        expect_now(ID_HALT, 0, "release_mcu_halt");
        expect_now(ID_ACK,  0, "release_ack");
        mcu_halted = 0;

        // Reset while granted with a ROM wait pending
        halt_req = 1; mcu_halted = 1;
        repeat (2) tick();
        expect_now(ID_ACK, 1, "grant_again");
        mcu_addr = 16'hC000; mcu_vma = 1; mcu_rnw = 1; rom_ok = 0;
        repeat (12) tick();
        rst = 1; halt_req = 0; mcu_halted = 0; mcu_vma = 0; rom_ok = 1;
        tick();
        rst = 0;
        expect_now(ID_HALT, 0, "rst_mcu_halt");
        expect_now(ID_ACK,  0, "rst_halt_ack");
        expect_now(ID_CEN,  0, "rst_mcu_cen");
        wait_cen();
        expect_now(ID_FIRST, 4, "first_cen_after_rst");
        wait_cen();
        expect_now(ID_GAP, 8, "cen_gap_after_rst");

        repeat (4) tick();
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain: actual %0d pending, required 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
